// File: rtl/vga_screen_ctrl.sv
// Screen/game sequencer: START/SPEED/PLAY/END flow, key presses and speed changes
// committed on the vga_vs rising edge, plus the speed-dependent game_tick.
`timescale 1ns/1ps
module vga_screen_ctrl #(
    parameter int unsigned MAX_LVL         = 4,
    parameter int unsigned FRAMES_PER_STEP = 6,
    parameter int unsigned END_FRAMES      = 180
) (
    input  logic       vga_clk_25,
    input  logic       rst_n,
    input  logic       vga_vs,
    input  logic       key_enter,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       game_over,
    output logic [3:0] state_m,
    output logic [2:0] speed_lvl,
    output logic       frame_tick,
    output logic       state_chg,
    output logic       game_tick
);

    localparam int unsigned TickW = $clog2(MAX_LVL * FRAMES_PER_STEP + 1);
    localparam int unsigned EndW  = $clog2(END_FRAMES + 1);

    typedef enum logic [3:0] {
        StStart = 4'b0001,
        StSpeed = 4'b0010,
        StPlay  = 4'b0100,
        StEnd   = 4'b1000
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       speed_q, speed_d;
    logic             vs_q;
    logic             p_enter_q, p_enter_d;
    logic             p_up_q, p_up_d;
    logic             p_down_q, p_down_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [EndW-1:0]  end_cnt_q, end_cnt_d;
    logic             state_chg_q;
    logic [TickW-1:0] period;

    assign frame_tick = vga_vs & ~vs_q;
    assign state_m    = state_q;
    assign speed_lvl  = speed_q;
    assign state_chg  = state_chg_q;
    assign period     = TickW'((MAX_LVL + 1 - 32'(speed_q)) * FRAMES_PER_STEP);

    always_comb begin
        state_d    = state_q;
        speed_d    = speed_q;
        tick_cnt_d = tick_cnt_q;
        end_cnt_d  = end_cnt_q;
        game_tick  = 1'b0;

        // Flags reload on the tick so a key landing on the tick cycle waits a frame.
        if (frame_tick) begin
            p_enter_d = key_enter;
            p_up_d    = key_up;
            p_down_d  = key_down;
        end else begin
            p_enter_d = p_enter_q | key_enter;
            p_up_d    = p_up_q | key_up;
            p_down_d  = p_down_q | key_down;
        end

        unique case (state_q)
            StStart: begin
                if (frame_tick && p_enter_q) state_d = StSpeed;
            end
            StSpeed: begin
                if (frame_tick) begin
                    if (p_enter_q) begin
                        state_d    = StPlay;
                        tick_cnt_d = '0;
                    end else if (p_up_q && !p_down_q) begin
                        if (speed_q < 3'(MAX_LVL)) speed_d = speed_q + 3'd1;
                    end else if (p_down_q && !p_up_q) begin
                        if (speed_q > 3'd1) speed_d = speed_q - 3'd1;
                    end
                end
            end
            StPlay: begin
                if (frame_tick) begin
                    if (game_over) begin
                        state_d   = StEnd;
                        end_cnt_d = '0;
                    end else if (tick_cnt_q == period - TickW'(1)) begin
                        game_tick  = 1'b1;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StEnd: begin
                if (frame_tick) begin
                    if (p_enter_q || end_cnt_q == EndW'(END_FRAMES - 1)) begin
                        state_d = StStart;
                    end else begin
                        end_cnt_d = end_cnt_q + EndW'(1);
                    end
                end
            end
            default: state_d = StStart;
        endcase
    end

    always_ff @(posedge vga_clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StStart;
            speed_q     <= 3'd1;
            vs_q        <= 1'b0;
            p_enter_q   <= 1'b0;
            p_up_q      <= 1'b0;
            p_down_q    <= 1'b0;
            tick_cnt_q  <= '0;
            end_cnt_q   <= '0;
            state_chg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            vs_q        <= vga_vs;
            p_enter_q   <= p_enter_d;
            p_up_q      <= p_up_d;
            p_down_q    <= p_down_d;
            tick_cnt_q  <= tick_cnt_d;
            end_cnt_q   <= end_cnt_d;
            state_chg_q <= (state_d != state_q);
        end
    end

endmodule

// File: tb/tb_vga_screen_ctrl.sv
// Scoreboard bench for vga_screen_ctrl: directed key/frame stimulus pushes expected
// screen, speed and game_tick events; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_vga_screen_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vga_vs;
    logic       key_enter;
    logic       key_up;
    logic       key_down;
    logic       game_over;
    logic [3:0] state_m;
    logic [2:0] speed_lvl;
    logic       frame_tick;
    logic       state_chg;
    logic       game_tick;

    vga_screen_ctrl #(
        .MAX_LVL        (4),
        .FRAMES_PER_STEP(2),
        .END_FRAMES     (3)
    ) dut (
        .vga_clk_25(clk),
        .rst_n     (rst_n),
        .vga_vs    (vga_vs),
        .key_enter (key_enter),
        .key_up    (key_up),
        .key_down  (key_down),
        .game_over (game_over),
        .state_m   (state_m),
        .speed_lvl (speed_lvl),
        .frame_tick(frame_tick),
        .state_chg (state_chg),
        .game_tick (game_tick)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pos = 0;
    int tb_frame = 0;
    int ft_cnt = 0;
    bit run = 1'b0;
    logic [2:0] prev_spd = 3'd1;
    int mv, mf;
    int q_st_val[$], q_st_frm[$], q_sp_val[$], q_sp_frm[$], q_gt_frm[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_st(input int v, input int f);
        q_st_val.push_back(v);
        q_st_frm.push_back(f);
    endtask

    task automatic exp_sp(input int v, input int f);
        q_sp_val.push_back(v);
        q_sp_frm.push_back(f);
    endtask

    task automatic exp_gt(input int f);
        q_gt_frm.push_back(f);
    endtask

    task automatic goto_pos(input int p);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (pos != p && n < 300);
        if (pos != p) begin
            errors++;
            $display("FAIL goto_pos: got pos %0d expected %0d", pos, p);
        end
    endtask

    task automatic adv_to(input int f);
        for (int i = 0; i < 40 && tb_frame < f; i++) goto_pos(50);
        if (tb_frame != f) begin
            errors++;
            $display("FAIL adv_to: got frame %0d expected %0d", tb_frame, f);
        end
    endtask

    // k: 0 enter, 1 up, 2 down
    task automatic pulse(input int k, input int p);
        goto_pos(p);
        case (k)
            0: key_enter = 1'b1;
            1: key_up = 1'b1;
            default: key_down = 1'b1;
        endcase
        @(posedge clk);
        #2;
        key_enter = 1'b0;
        key_up    = 1'b0;
        key_down  = 1'b0;
    endtask

    // Synthetic frame: 100 clocks, vga_vs low for the first 4.
    initial begin
        vga_vs = 1'b0;
        wait (run);
        forever begin
            @(posedge clk);
            #1;
            pos    = (pos == 99) ? 0 : pos + 1;
            vga_vs = (pos >= 4);
            if (pos == 4) tb_frame++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_spd = speed_lvl;
            end else begin
                if (frame_tick) ft_cnt++;
                if (game_tick) begin
                    checks++;
                    if (q_gt_frm.size() == 0) begin
                        errors++;
                        $display("FAIL game_tick: got pulse at frame %0d expected none", tb_frame);
                    end else begin
                        mf = q_gt_frm.pop_front();
                        if (mf != tb_frame || !frame_tick) begin
                            errors++;
                            $display("FAIL game_tick: got frame %0d ft %0b expected frame %0d ft 1",
                                     tb_frame, frame_tick, mf);
                        end
                    end
                end
                if (state_chg) begin
                    checks++;
                    if (q_st_val.size() == 0) begin
                        errors++;
                        $display("FAIL state_chg: got state %b frame %0d expected no change",
                                 state_m, tb_frame);
                    end else begin
                        mv = q_st_val.pop_front();
                        mf = q_st_frm.pop_front();
                        if (int'(state_m) != mv || tb_frame != mf) begin
                            errors++;
                            $display("FAIL state_chg: got state %b frame %0d expected %b frame %0d",
                                     state_m, tb_frame, mv[3:0], mf);
                        end
                    end
                end
                if (speed_lvl != prev_spd) begin
                    checks++;
                    if (q_sp_val.size() == 0) begin
                        errors++;
                        $display("FAIL speed: got %0d frame %0d expected no change",
                                 speed_lvl, tb_frame);
                    end else begin
                        mv = q_sp_val.pop_front();
                        mf = q_sp_frm.pop_front();
                        if (int'(speed_lvl) != mv || tb_frame != mf) begin
                            errors++;
                            $display("FAIL speed: got %0d frame %0d expected %0d frame %0d",
                                     speed_lvl, tb_frame, mv, mf);
                        end
                    end
                    prev_spd = speed_lvl;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_ent, q_ent;
        rst_n     = 1'b0;
        key_enter = 1'b0;
        key_up    = 1'b0;
        key_down  = 1'b0;
        game_over = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", state_m, 1);
        chk("rst_speed", speed_lvl, 1);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_state_chg", state_chg, 0);
        chk("rst_game_tick", game_tick, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run   = 1'b1;

        // Idle frames
        adv_to(3);
        chk("idle_ticks", ft_cnt, 3);
        chk("idle_state", state_m, 1);
        chk("idle_speed", speed_lvl, 1);

        // Enter mid-frame
        pulse(0, 50);
        exp_st(4'b0010, tb_frame + 1);
        goto_pos(50);
        chk("speed_screen", state_m, 2);

        // Speed up with saturation
        for (int i = 0; i < 5; i++) begin
            pulse(1, 50);
            if (i < 3) exp_sp(i + 2, tb_frame + 1);
        end
        goto_pos(50);
        chk("speed_sat_hi", speed_lvl, 4);

        // Multiple presses in one frame collapse
        pulse(2, 20); pulse(2, 40); pulse(2, 60);
        exp_sp(3, tb_frame + 1);
        pulse(1, 20); pulse(1, 40); pulse(1, 60);
        exp_sp(4, tb_frame + 1);
        pulse(1, 30); pulse(2, 60);
        goto_pos(50);
        chk("up_down_same_frame", speed_lvl, 4);

        for (int i = 0; i < 3; i++) begin
            pulse(2, 50);
            exp_sp(3 - i, tb_frame + 1);
        end
        for (int i = 0; i < 5; i++) pulse(2, 50);
        goto_pos(50);
        chk("speed_sat_lo", speed_lvl, 1);
        pulse(1, 50); exp_sp(2, tb_frame + 1);
        pulse(1, 50); exp_sp(3, tb_frame + 1);

        // Enter on the tick cycle is deferred a frame
        pulse(0, 4);
        p_ent = tb_frame + 1;
        exp_st(4'b0100, p_ent);
        goto_pos(50);
        chk("enter_deferred", state_m, 2);

        // PLAY at speed 3: period 4; up/enter ignored
        exp_gt(p_ent + 4);
        exp_gt(p_ent + 8);
        pulse(1, 50);
        pulse(0, 50);
        adv_to(p_ent + 11);
        chk("play_keys_speed", speed_lvl, 3);
        chk("play_keys_state", state_m, 4);
        game_over = 1'b1;
        exp_st(4'b1000, p_ent + 12);
        goto_pos(50);
        game_over = 1'b0;
        chk("end_screen", state_m, 8);
        exp_st(4'b0001, p_ent + 15);
        adv_to(p_ent + 15);
        chk("speed_retained", speed_lvl, 3);

        // PLAY at speed 1: period 8; enter leaves END early
        pulse(0, 50); exp_st(4'b0010, tb_frame + 1);
        pulse(2, 50); exp_sp(2, tb_frame + 1);
        pulse(2, 50); exp_sp(1, tb_frame + 1);
        pulse(0, 50);
        q_ent = tb_frame + 1;
        exp_st(4'b0100, q_ent);
        exp_gt(q_ent + 8);
        exp_gt(q_ent + 16);
        adv_to(q_ent + 17);
        game_over = 1'b1;
        exp_st(4'b1000, q_ent + 18);
        goto_pos(30);
        game_over = 1'b0;
        pulse(0, 50);
        exp_st(4'b0001, q_ent + 19);
        goto_pos(50);
        chk("end_enter_start", state_m, 1);

        // Asynchronous reset in PLAY
        pulse(0, 50); exp_st(4'b0010, tb_frame + 1);
        pulse(1, 50); exp_sp(2, tb_frame + 1);
        pulse(0, 50); exp_st(4'b0100, tb_frame + 1);
        goto_pos(50);
        chk("pre_reset_state", state_m, 4);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", state_m, 1);
        chk("async_rst_speed", speed_lvl, 1);
        goto_pos(1);
        rst_n = 1'b1;
        goto_pos(50);
        chk("post_rst_state", state_m, 1);
        chk("frame_tick_count", ft_cnt, tb_frame);

        repeat (2) @(posedge clk);
        chk("q_state_empty", q_st_val.size(), 0);
        chk("q_speed_empty", q_sp_val.size(), 0);
        chk("q_gtick_empty", q_gt_frm.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_screen_ctrl.md
Name: vga_screen_ctrl

Overview:
Screen/game sequencer that drives the one-hot screen-select bus into the VGA driver.
- Takes single-cycle key pulses and a game-over level, and runs the START/SPEED/PLAY/END flow.
- Screen and speed changes are committed only at a frame boundary (rising edge of vga_vs), so a switch never tears mid-frame.
- Generates the speed-dependent game_tick consumed by the game logic.

Parameters:
MAX_LVL, 4, highest speed level; speed_lvl range is 1..MAX_LVL (MAX_LVL <= 7).
FRAMES_PER_STEP, 6, frames per speed step; game_tick period = (MAX_LVL+1-speed_lvl)*FRAMES_PER_STEP frames.
END_FRAMES, 180, frames spent in END before automatic return to START.

Ports:
vga_clk_25  in  1  pixel clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
vga_vs  in  1  vertical sync from VGA driver, low during sync lines.
key_enter  in  1  one-cycle pulse, confirm.
key_up  in  1  one-cycle pulse, speed +1.
key_down  in  1  one-cycle pulse, speed -1.
game_over  in  1  level from game logic, sampled only in PLAY.
state_m  out  4  one-hot screen: 0001 START, 0010 SPEED, 0100 PLAY, 1000 END.
speed_lvl  out  3  current speed level.
frame_tick  out  1  one-cycle pulse on the vga_vs rising edge.
state_chg  out  1  one-cycle pulse in the cycle after state_m changes.
game_tick  out  1  one-cycle pulse, PLAY only.

Behaviour:
- Reset: one clock, vga_clk_25; reset is asynchronous, active-low (rst_n).
  - Outputs: state_m=0001, speed_lvl=1, frame_tick=0, state_chg=0, game_tick=0.
  - Internal: vs_d=0, all pending flags=0, tick_cnt=0, end_cnt=0.
  - Reset mid-operation aborts the current state immediately, no frame-boundary wait.
- Frame tick: vs_d registers vga_vs; frame_tick = vga_vs & ~vs_d, combinational, one cycle.
- Pending capture:
  - Any cycle with key_enter sets p_enter; key_up sets p_up; key_down sets p_down.
  - Multiple presses within one frame collapse to one.
  - On a frame_tick cycle, the apply step uses the registered pending flags only.
  - In that same cycle the flags are reloaded from that cycle's key inputs, so a key arriving on the tick cycle applies at the next frame.
- Apply step (frame_tick cycles only):
  - START: p_enter -> SPEED.
  - SPEED:
    - p_enter -> PLAY; tick_cnt cleared; p_up/p_down ignored.
    - Otherwise p_up alone -> speed_lvl+1, saturating at MAX_LVL.
    - p_down alone -> speed_lvl-1, saturating at 1.
    - p_up and p_down together -> no change.
  - PLAY:
    - game_over=1 -> END; end_cnt cleared; no game_tick that frame.
    - Otherwise tick_cnt+1; when tick_cnt reaches period-1, game_tick=1 that cycle and tick_cnt returns to 0.
    - First game_tick after entry comes on the period-th frame tick.
  - END: p_enter, or end_cnt==END_FRAMES-1 -> START. Otherwise end_cnt+1. speed_lvl is retained across games.
- Keys outside their states: key_up/key_down outside SPEED and key_enter in PLAY are discarded at apply.
- Timing:
  - state_m and speed_lvl update at the clock edge ending the frame_tick cycle.
  - state_chg is high the following cycle.
  - state_m is always exactly one-hot; an illegal encoding recovers to START on the next clock.
- Widths:
  - tick_cnt wide enough for MAX_LVL*FRAMES_PER_STEP.
  - end_cnt wide enough for END_FRAMES.
  - period is computed from the registered speed_lvl.

Test Plan:
Common parameters for all scenarios: MAX_LVL=4, FRAMES_PER_STEP=2, END_FRAMES=3. Bench drives vga_vs with a short synthetic frame, 100 clocks per frame, low for first 4.
1. Reset then 3 frames, no keys -> state_m=0001, speed_lvl=1, game_tick never high, frame_tick exactly 3 pulses; assert rst_n low mid-frame in a later state -> state_m=0001 in the same cycle.
2. key_enter mid-frame 0 -> state_m=0010 only after the next vga_vs rise, state_chg high one cycle later; key_enter on the exact frame_tick cycle -> transition deferred one further frame.
3. In SPEED: 5 key_up pulses spread over 5 frames -> speed_lvl 2,3,4,4,4; 3 key_up in one frame -> +1 only; up and down same frame -> unchanged; 5 key_down from 1 -> stays 1.
4. speed_lvl=3, enter PLAY -> game_tick every (4+1-3)*2=4 frames, first on the 4th frame tick; at speed_lvl=1 -> every 8 frames.
5. PLAY with game_over raised mid-frame -> END at next frame tick, no game_tick that frame; no keys -> START after 3 further frame ticks; key_enter in END -> START at next frame tick.
6. key_up in PLAY and key_enter in PLAY -> speed_lvl and state_m unchanged.
